uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit path: accepts a parallel byte on a single-cycle request and
//   serialises it onto tx_dataout as start bit, data bits (LSB first), optional
//   parity and stop bit(s). Runs on the same 16x-oversample clk as the receive
//   path, so each bit is held for OVERSAMPLE clk cycles. It is the transmit
//   counterpart to rx_detect_start and the rest of the receive chain.
// PARAMETERS
//   DATA_BITS   8   data bits per frame (5..9)
//   OVERSAMPLE  16  clk cycles per bit period (>=2); must match the receiver
//   PARITY_EN   0   1 = insert a parity bit after the data bits
//   PARITY_ODD  0   0 = even parity, 1 = odd parity (used only if PARITY_EN=1)
//   STOP_BITS   1   number of stop bits (1 or 2)
// PORTS
//   clk         in   1          16x oversample clock; all logic on posedge
//   rst         in   1          synchronous, active-high reset
//   tx_start    in   1          request; sampled only while idle
//   tx_datain   in   DATA_BITS  byte to send; captured on the accepted request
//   tx_busy     out  1          high while a frame is in progress
//   tx_done     out  1          one-cycle pulse after the last stop-bit cycle
//   tx_dataout  out  1          serial line; idle level is 1
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, tx_dataout=1, tx_busy=0,
//     tx_done=0, bit counter=0, sample counter=0. rst overrides tx_start.
//   - All outputs are registered.
//   - States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
//   - IDLE: tx_dataout=1. If tx_start=1 at edge N, capture tx_datain into the
//     shift register. Parity = ^data, inverted when PARITY_ODD=1.
//     From cycle N+1: state=START, tx_busy=1, tx_dataout=0.
//   - Each bit state holds its line value for exactly OVERSAMPLE cycles.
//     The sample counter runs 0..OVERSAMPLE-1 and the state advances on the
//     wrap. Counter width is $clog2(OVERSAMPLE).
//   - DATA: bit k (k=0..DATA_BITS-1) drives data[k], LSB first. The bit
//     counter is $clog2(DATA_BITS+1) wide and leaves DATA after DATA_BITS bits.
//   - PARITY: drives the computed parity bit for one bit period.
//   - STOP: drives 1 for STOP_BITS*OVERSAMPLE cycles.
//   - Frame time: (1+DATA_BITS+PARITY_EN+STOP_BITS)*OVERSAMPLE cycles of
//     tx_busy=1, starting at cycle N+1.
//   - In the first cycle back in IDLE: tx_done=1 for that cycle only, and
//     tx_busy=0. A tx_start in that same cycle is accepted, so frames can run
//     back to back with the line never leaving 1 for more than one cycle
//     between the last stop bit and the next start bit.
//   - tx_start while tx_busy=1 is ignored: not queued, no error.
//   - tx_datain changes after capture do not affect the frame in flight.
//   - Reset mid-frame: the next cycle shows line=1, busy=0, and no tx_done
//     pulse. The aborted frame is discarded.
// STRUCTURE
//   - Shared package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP),
//     IDLE_LEVEL=1'b1, START_LEVEL=1'b0. The same constants are reused by the
//     receive path.
//   - One sub-module, uart_bit_timer (parameter OVERSAMPLE): a sample counter
//     with clear and enable inputs, emitting a one-cycle bit_end strobe on
//     wrap. The receive path can reuse it.
//   - Top level: FSM, shift register, bit counter, parity register, output
//     registers.
// TESTING
//   1. Reset: hold rst 3 cycles, then check line=1, busy=0, done=0 for 50
//      cycles with tx_start=0.
//   2. Basic frame (defaults): tx_datain=8'hA5 with 1-cycle tx_start at N.
//      Expect a low from N+1 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16
//      cycles each, then 16 cycles high. tx_done at N+161, busy high
//      N+1..N+160.
//   3. Parity: PARITY_EN=1, PARITY_ODD=0, data 8'h07 -> parity bit 1.
//      PARITY_ODD=1 -> 0. Frame is 176 cycles.
//   4. Busy drop and back to back:
//      - Pulse tx_start with 8'h3C mid-frame -> ignored, and the current
//        byte is unchanged.
//      - Pulse tx_start with 8'h3C in the tx_done cycle -> the start bit
//        begins the next cycle.
//   5. Reset mid-frame: assert rst during data bit 3. Expect line=1 and
//      busy=0 the next cycle, no tx_done, then a clean new frame.
//   6. Loopback: connect tx_dataout to the receive chain and send 0x00,
//      0xFF, 0x55 and 0xAA. Each is detected by rx_detect_start and
//      recovered intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels used by both
// the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..OVERSAMPLE-1 while enabled and strobes o_bit_end
// during the last count of each bit period.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] r_cnt;

  assign o_bit_end = i_en && !i_clr && (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= o_bit_end ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: serialises a captured word as start, LSB-first data,
// optional parity and stop bit(s), each bit held for OVERSAMPLE clocks.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_datain,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_dataout
);

  localparam int            BW        = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]        r_bitcnt, w_bitcnt_nxt;
  logic                 r_parity, w_parity_nxt;
  logic                 r_line, w_line_nxt;
  logic                 r_busy, r_done, w_done_nxt;
  logic                 w_bit_end;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == IDLE),
    .i_en      (r_state != IDLE),
    .o_bit_end (w_bit_end)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_parity_nxt = r_parity;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_state_nxt  = START;
          w_shift_nxt  = tx_datain;
          w_parity_nxt = (^tx_datain) ^ (PARITY_ODD != 0);
          w_bitcnt_nxt = '0;
        end
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bitcnt == LAST_DATA) begin
            w_bitcnt_nxt = '0;
            w_state_nxt  = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_end) w_state_nxt = STOP;
      end
      STOP: begin
        // Bit counter is reused to count stop bits.
        if (w_bit_end) begin
          if (r_bitcnt == LAST_STOP) begin
            w_state_nxt  = IDLE;
            w_bitcnt_nxt = '0;
            w_done_nxt   = 1'b1;
          end else begin
            w_bitcnt_nxt = r_bitcnt + BW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line value is derived from the next state so the output register
    // lines up exactly with the state register.
    w_line_nxt = IDLE_LEVEL;
    case (w_state_nxt)
      START:   w_line_nxt = START_LEVEL;
      DATA:    w_line_nxt = w_shift_nxt[0];
      PARITY:  w_line_nxt = r_parity;
      default: w_line_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_parity <= 1'b0;
      r_line   <= IDLE_LEVEL;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_parity <= w_parity_nxt;
      r_line   <= w_line_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_done   <= w_done_nxt;
    end
  end

  assign tx_dataout = r_line;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: cycle-exact frame checks plus a
// bench-side receiver that decodes the line against a queue of sent bytes.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = 3'b000;
  logic [7:0] datain = 8'h00;
  logic [2:0] busy, done, line;

  int         nasserts = 0;
  int         nfail = 0;
  int         nrx = 0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  uart_tx_serializer u_dut0 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .tx_datain(datain),
    .tx_busy(busy[0]), .tx_done(done[0]), .tx_dataout(line[0]));

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_pe (
    .clk(clk), .rst(rst), .tx_start(start[1]), .tx_datain(datain),
    .tx_busy(busy[1]), .tx_done(done[1]), .tx_dataout(line[1]));

  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut_po (
    .clk(clk), .rst(rst), .tx_start(start[2]), .tx_datain(datain),
    .tx_busy(busy[2]), .tx_done(done[2]), .tx_dataout(line[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasserts++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives (or continues) a frame on DUT sel and checks line/busy/done every
  // cycle from N+1 through the tx_done cycle.
  task automatic check_frame(input int sel, input logic [7:0] d, input bit drive,
                             input bit mid_ign, input bit arm, input logic [7:0] nd);
    bit pe, po;
    int f, idx;
    logic el, eb, ed;
    pe = (sel != 0);
    po = (sel == 2);
    f  = (10 + int'(pe)) * 16;
    if (drive) begin
      @(posedge clk); #1;
      datain = d;
      start[sel] = 1'b1;
      if (sel == 0) sbq.push_back(d);
    end
    @(posedge clk); #1;
    start[sel] = 1'b0;
    for (int k = 1; k <= f + 1; k++) begin
      @(negedge clk);
      if (k <= f) begin
        idx = (k - 1) / 16;
        if (idx == 0)            el = 1'b0;
        else if (idx <= 8)       el = d[idx-1];
        else if (pe && idx == 9) el = (^d) ^ po;
        else                     el = 1'b1;
        eb = 1'b1;
        ed = 1'b0;
      end else begin
        el = 1'b1;
        eb = 1'b0;
        ed = 1'b1;
      end
      chk($sformatf("line dut%0d d=%0h k=%0d", sel, d, k), line[sel], el);
      chk($sformatf("busy dut%0d d=%0h k=%0d", sel, d, k), busy[sel], eb);
      chk($sformatf("done dut%0d d=%0h k=%0d", sel, d, k), done[sel], ed);
      if (mid_ign && k == 40) begin
        datain = 8'h3C;
        start[sel] = 1'b1;
      end
      if (mid_ign && k == 41) start[sel] = 1'b0;
      if (arm && k == f + 1) begin
        datain = nd;
        start[sel] = 1'b1;
        if (sel == 0) sbq.push_back(nd);
      end
    end
  endtask

  // Receiver model on dut0: samples mid-bit, discards frames that saw reset.
  initial begin : rx_mon
    logic [7:0] b;
    logic [7:0] exp;
    bit ab;
    forever begin
      @(negedge clk);
      if (!rst && line[0] === 1'b0) begin
        ab = 1'b0;
        for (int i = 0; i < 7; i++) begin @(negedge clk); if (rst) ab = 1'b1; end
        if (line[0] !== 1'b0) ab = 1'b1;
        for (int j = 0; j < 8; j++) begin
          for (int i = 0; i < 16; i++) begin @(negedge clk); if (rst) ab = 1'b1; end
          b[j] = line[0];
        end
        for (int i = 0; i < 16; i++) begin @(negedge clk); if (rst) ab = 1'b1; end
        if (!ab) begin
          nrx++;
          exp = (sbq.size() > 0) ? sbq.pop_front() : 8'hxx;
          chk($sformatf("rx_byte #%0d", nrx), {24'h0, b}, {24'h0, exp});
          chk($sformatf("rx_stop #%0d", nrx), line[0], 1'b1);
        end
      end
    end
  end

  initial begin
    // Reset held for 3 cycles, then a quiet idle line.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("rst_line", line[0], 1'b1);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_done", done[0], 1'b0);
    end

    // Basic frame, then ignored mid-frame request and back-to-back 3C.
    check_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
    check_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h3C);
    check_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00);

    // Parity: 0x07 gives 1 for even and 0 for odd parity.
    check_frame(1, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00);
    check_frame(2, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reset during data bit 3 of a frame on dut0.
    @(posedge clk); #1;
    datain = 8'h5A;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (70) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_line", line[0], 1'b1);
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_done", done[0], 1'b0);
    #1 rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      chk($sformatf("postrst_done k=%0d", k), done[0], 1'b0);
      chk($sformatf("postrst_line k=%0d", k), line[0], 1'b1);
    end
    check_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 8'h00);

    // Loopback patterns through the receiver model.
    check_frame(0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    check_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00);
    check_frame(0, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00);
    check_frame(0, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00);

    repeat (20) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("rx_frames", nrx, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
